// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU has fixed priority, and DMA gets a forced grant after MAX_WAIT cycles of contention.
// Reads return RD_LAT cycles after the grant. DMA accesses to the I/O window are suppressed and flagged on dma_err.
module dmem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int RD_LAT   = 1
) (
  input  logic        mem_clk,
  input  logic        clrn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_gnt,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_datain,
  output logic        m_we,
  input  logic [31:0] m_rdata
);

  typedef struct packed {
    logic vld;
    logic dma;
  } rd_tag_t;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic [7:0]  wait_q, wait_d;
  logic        force_gnt;
  logic        dma_io;
  logic        dma_err_q, dma_err_d;
  rd_tag_t     tag_d;
  rd_tag_t     tag_q [RD_LAT];
  rd_tag_t     tag_out;
  logic [31:0] cpu_rdata_q, dma_rdata_q;

  assign dma_io    = (dma_addr[31:8] == 24'hffffff);
  assign force_gnt = dma_req & (wait_q == MaxWait);
  assign dma_gnt   = dma_req & (~cpu_req | force_gnt);
  assign cpu_gnt   = cpu_req & ~dma_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  // A suppressed I/O-window DMA access still owns the slot but never writes.
  always_comb begin
    m_addr   = '0;
    m_datain = '0;
    m_we     = 1'b0;
    if (cpu_gnt) begin
      m_addr   = cpu_addr;
      m_datain = cpu_wdata;
      m_we     = cpu_we;
    end else if (dma_gnt) begin
      m_addr   = dma_addr;
      m_datain = dma_wdata;
      m_we     = dma_we & ~dma_io;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (~dma_req | dma_gnt) begin
      wait_d = '0;
    end else if (wait_q != MaxWait) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_comb begin
    tag_d.vld = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we & ~dma_io);
    tag_d.dma = dma_gnt;
  end

  assign dma_err_d = dma_gnt & dma_io;
  assign tag_out   = tag_q[RD_LAT-1];

  // Return data is live from memory on the valid cycle and held afterwards.
  assign cpu_rvalid = tag_out.vld & ~tag_out.dma;
  assign dma_rvalid = tag_out.vld & tag_out.dma;
  assign cpu_rdata  = cpu_rvalid ? m_rdata : cpu_rdata_q;
  assign dma_rdata  = dma_rvalid ? m_rdata : dma_rdata_q;
  assign dma_err    = dma_err_q;

  always_ff @(posedge mem_clk or negedge clrn) begin
    if (!clrn) begin
      wait_q      <= '0;
      dma_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      wait_q    <= wait_d;
      dma_err_q <= dma_err_d;
      tag_q[0]  <= tag_d;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (cpu_rvalid) begin
        cpu_rdata_q <= m_rdata;
      end
      if (dma_rvalid) begin
        dma_rdata_q <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (RD_LAT 1 and 2) share stimulus and are checked
// against a cycle-level model built from the arbitration and read-return rules.
module tb_dmem_port_arbiter;

  localparam int MAXW = 4;

  logic        mem_clk = 1'b0;
  logic        clrn = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0, m_rdata = '0;

  logic        cpu_stall_o [1:2];
  logic        cpu_gnt_o   [1:2];
  logic [31:0] cpu_rdata_o [1:2];
  logic        cpu_rvalid_o[1:2];
  logic        dma_gnt_o   [1:2];
  logic [31:0] dma_rdata_o [1:2];
  logic        dma_rvalid_o[1:2];
  logic        dma_err_o   [1:2];
  logic [31:0] m_addr_o    [1:2];
  logic [31:0] m_datain_o  [1:2];
  logic        m_we_o      [1:2];

  always #5 mem_clk = ~mem_clk;

  dmem_port_arbiter #(.MAX_WAIT(MAXW), .RD_LAT(1)) u_lat1 (
    .mem_clk(mem_clk), .clrn(clrn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall_o[1]), .cpu_gnt(cpu_gnt_o[1]), .cpu_rdata(cpu_rdata_o[1]), .cpu_rvalid(cpu_rvalid_o[1]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_o[1]), .dma_rdata(dma_rdata_o[1]), .dma_rvalid(dma_rvalid_o[1]), .dma_err(dma_err_o[1]),
    .m_addr(m_addr_o[1]), .m_datain(m_datain_o[1]), .m_we(m_we_o[1]), .m_rdata(m_rdata)
  );

  dmem_port_arbiter #(.MAX_WAIT(MAXW), .RD_LAT(2)) u_lat2 (
    .mem_clk(mem_clk), .clrn(clrn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall_o[2]), .cpu_gnt(cpu_gnt_o[2]), .cpu_rdata(cpu_rdata_o[2]), .cpu_rvalid(cpu_rvalid_o[2]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_o[2]), .dma_rdata(dma_rdata_o[2]), .dma_rvalid(dma_rvalid_o[2]), .dma_err(dma_err_o[2]),
    .m_addr(m_addr_o[2]), .m_datain(m_datain_o[2]), .m_we(m_we_o[2]), .m_rdata(m_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: contention count, scheduled returns per latency, held return data.
  int          mw;
  int          cyc = 0;
  bit          rv_cpu [1:2][16];
  bit          rv_dma [1:2][16];
  logic [31:0] hold_cpu [1:2];
  logic [31:0] hold_dma [1:2];
  bit          err_exp;
  bit          last_cg, last_dg;

  function automatic bit in_io(input logic [31:0] a);
    return a >= 32'hFFFF_FF00;
  endfunction

  function automatic void model_comb(output bit dg, output bit cg, output logic [31:0] ma,
                                     output logic [31:0] md, output bit we);
    bit frc;
    frc = dma_req && (mw == MAXW);
    dg  = dma_req && (!cpu_req || frc);
    cg  = cpu_req && !dg;
    ma  = 0; md = 0; we = 0;
    if (cg) begin
      ma = cpu_addr; md = cpu_wdata; we = cpu_we;
    end else if (dg) begin
      ma = dma_addr; md = dma_wdata; we = dma_we && !in_io(dma_addr);
    end
  endfunction

  task automatic model_reset();
    mw = 0;
    err_exp = 0;
    last_cg = 0;
    last_dg = 0;
    for (int l = 1; l <= 2; l++) begin
      hold_cpu[l] = 0;
      hold_dma[l] = 0;
      for (int s = 0; s < 16; s++) begin
        rv_cpu[l][s] = 0;
        rv_dma[l][s] = 0;
      end
    end
  endtask

  // Apply the current cycle to the model, then move to just after the next rising edge.
  task automatic advance();
    bit dg, cg, we;
    logic [31:0] ma, md;
    int slot;
    model_comb(dg, cg, ma, md, we);
    slot = cyc % 16;
    for (int l = 1; l <= 2; l++) begin
      if (rv_cpu[l][slot]) hold_cpu[l] = m_rdata;
      if (rv_dma[l][slot]) hold_dma[l] = m_rdata;
      rv_cpu[l][slot] = 0;
      rv_dma[l][slot] = 0;
      if (cg && !cpu_we) rv_cpu[l][(cyc + l) % 16] = 1;
      if (dg && !dma_we && !in_io(dma_addr)) rv_dma[l][(cyc + l) % 16] = 1;
    end
    err_exp = dg && in_io(dma_addr);
    if (!dma_req || dg) mw = 0;
    else if (mw < MAXW) mw = mw + 1;
    last_cg = cg;
    last_dg = dg;
    cyc++;
    @(posedge mem_clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clrn = 0;
    repeat (2) @(posedge mem_clk);
    #1 clrn = 1;
    model_reset();
    @(negedge mem_clk);
    for (int l = 1; l <= 2; l++) begin
      n_chk++;
      if ({cpu_stall_o[l], cpu_gnt_o[l], cpu_rvalid_o[l], dma_gnt_o[l], dma_rvalid_o[l], dma_err_o[l],
           m_we_o[l], cpu_rdata_o[l], dma_rdata_o[l], m_addr_o[l], m_datain_o[l]} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle lat=%0d: outputs not all zero (cpu_rdata=%h m_addr=%h)", l, cpu_rdata_o[l], m_addr_o[l]);
      end
    end
    #1 advance();
    // Start a read, then pull reset while it is still in flight in the RD_LAT=2 instance.
    cpu_req = 1; cpu_addr = 32'h40; m_rdata = 32'hA5A5_0001;
    advance();
    cpu_req = 0;
    #2 clrn = 0;
    #1;
    for (int l = 1; l <= 2; l++) begin
      n_chk++;
      if ({cpu_stall_o[l], cpu_gnt_o[l], cpu_rvalid_o[l], dma_gnt_o[l], dma_rvalid_o[l], dma_err_o[l],
           m_we_o[l], cpu_rdata_o[l], dma_rdata_o[l], m_addr_o[l], m_datain_o[l]} !== '0) begin
        n_fail++;
        $display("FAIL reset_midread lat=%0d: outputs not zero (rvalid=%b rdata=%h)", l, cpu_rvalid_o[l], cpu_rdata_o[l]);
      end
    end
    repeat (2) @(posedge mem_clk);
    #1 clrn = 1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge mem_clk);
      for (int l = 1; l <= 2; l++) begin
        n_chk++;
        if (cpu_rvalid_o[l] !== 1'b0 || dma_rvalid_o[l] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_norvalid lat=%0d k=%0d: cpu_rvalid=%b dma_rvalid=%b, want 0", l, k, cpu_rvalid_o[l], dma_rvalid_o[l]);
        end
      end
      advance();
    end
  endtask

  task automatic test_cpu_read();
    m_rdata = 32'hDEAD_BEEF;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge mem_clk);
    n_chk++;
    if (cpu_gnt_o[1] !== 1'b1 || m_addr_o[1] !== 32'h10 || m_we_o[1] !== 1'b0 || cpu_stall_o[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_read_grant: gnt=%b addr=%h we=%b stall=%b, want 1 00000010 0 0", cpu_gnt_o[1], m_addr_o[1], m_we_o[1], cpu_stall_o[1]);
    end
    advance();
    cpu_req = 0;
    @(negedge mem_clk);
    n_chk++;
    if (cpu_rvalid_o[1] !== 1'b1 || cpu_rdata_o[1] !== 32'hDEAD_BEEF || cpu_rvalid_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_read_lat1: rvalid1=%b rdata1=%h rvalid2=%b, want 1 deadbeef 0", cpu_rvalid_o[1], cpu_rdata_o[1], cpu_rvalid_o[2]);
    end
    advance();
    @(negedge mem_clk);
    n_chk++;
    if (cpu_rvalid_o[2] !== 1'b1 || cpu_rdata_o[2] !== 32'hDEAD_BEEF || cpu_rvalid_o[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_read_lat2: rvalid2=%b rdata2=%h rvalid1=%b, want 1 deadbeef 0", cpu_rvalid_o[2], cpu_rdata_o[2], cpu_rvalid_o[1]);
    end
    advance();
    m_rdata = 32'h1234_5678;
    @(negedge mem_clk);
    n_chk++;
    if (cpu_rdata_o[1] !== 32'hDEAD_BEEF || cpu_rdata_o[2] !== 32'hDEAD_BEEF || cpu_rvalid_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_read_hold: rdata1=%h rdata2=%h rvalid2=%b, want deadbeef deadbeef 0", cpu_rdata_o[1], cpu_rdata_o[2], cpu_rvalid_o[2]);
    end
    advance();
  endtask

  task automatic test_starvation();
    bit exp_d;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    dma_req = 1; dma_we = 0; dma_addr = 32'h200;
    for (int k = 0; k < 10; k++) begin
      m_rdata = 32'h5000_0000 + k;
      exp_d = (k == 4) || (k == 9);
      @(negedge mem_clk);
      n_chk++;
      if (dma_gnt_o[1] !== exp_d || cpu_gnt_o[1] !== !exp_d || cpu_stall_o[1] !== exp_d ||
          m_addr_o[1] !== (exp_d ? 32'h200 : 32'h100)) begin
        n_fail++;
        $display("FAIL starvation k=%0d: dma_gnt=%b cpu_gnt=%b stall=%b addr=%h, want dma_gnt=%b", k,
                 dma_gnt_o[1], cpu_gnt_o[1], cpu_stall_o[1], m_addr_o[1], exp_d);
      end
      if (k == 5) begin
        n_chk++;
        if (dma_rvalid_o[1] !== 1'b1 || dma_rdata_o[1] !== 32'h5000_0005 || cpu_rvalid_o[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL starvation_dma_return: dma_rvalid=%b dma_rdata=%h cpu_rvalid=%b, want 1 50000005 0",
                   dma_rvalid_o[1], dma_rdata_o[1], cpu_rvalid_o[1]);
        end
      end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  task automatic test_dma_io();
    dma_req = 1; dma_we = 1; dma_addr = 32'hFFFF_FF20; dma_wdata = 32'h7F;
    @(negedge mem_clk);
    n_chk++;
    if (dma_gnt_o[1] !== 1'b1 || m_we_o[1] !== 1'b0 || m_addr_o[1] !== 32'hFFFF_FF20 || dma_err_o[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL dma_io_grant: gnt=%b we=%b addr=%h err=%b, want 1 0 ffffff20 0", dma_gnt_o[1], m_we_o[1], m_addr_o[1], dma_err_o[1]);
    end
    advance();
    dma_we = 0; dma_addr = 32'hFFFF_FF04;
    @(negedge mem_clk);
    n_chk++;
    if (dma_err_o[1] !== 1'b1 || dma_err_o[2] !== 1'b1 || dma_rvalid_o[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL dma_io_err: err1=%b err2=%b rvalid=%b, want 1 1 0", dma_err_o[1], dma_err_o[2], dma_rvalid_o[1]);
    end
    advance();
    dma_req = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge mem_clk);
      n_chk++;
      if (dma_rvalid_o[1] !== 1'b0 || dma_rvalid_o[2] !== 1'b0 || dma_err_o[1] !== (k == 0)) begin
        n_fail++;
        $display("FAIL dma_io_read k=%0d: rvalid1=%b rvalid2=%b err=%b, want 0 0 %b", k, dma_rvalid_o[1], dma_rvalid_o[2], dma_err_o[1], k == 0);
      end
      advance();
    end
  endtask

  task automatic test_cpu_io();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'hFFFF_FF80; cpu_wdata = 32'h3FF;
    @(negedge mem_clk);
    n_chk++;
    if (m_we_o[1] !== 1'b1 || m_addr_o[1] !== 32'hFFFF_FF80 || m_datain_o[1] !== 32'h3FF || cpu_gnt_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL cpu_io_write: we=%b addr=%h data=%h gnt=%b, want 1 ffffff80 000003ff 1", m_we_o[1], m_addr_o[1], m_datain_o[1], cpu_gnt_o[1]);
    end
    advance();
    idle_inputs();
    @(negedge mem_clk);
    n_chk++;
    if (cpu_rvalid_o[1] !== 1'b0 || dma_err_o[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_io_after: rvalid=%b err=%b, want 0 0", cpu_rvalid_o[1], dma_err_o[1]);
    end
    advance();
  endtask

  task automatic test_interleaved();
    bit dg, cg, we;
    logic [31:0] ma, md;
    int slot;
    for (int k = 0; k < 16; k++) begin
      cpu_we = 0; dma_we = 0;
      cpu_req = (k < 12) && (k % 2 == 0);
      dma_req = (k < 12) && (k % 2 == 1);
      cpu_addr = 32'h1000 + k * 4;
      dma_addr = 32'h2000 + k * 4;
      m_rdata = $urandom;
      @(negedge mem_clk);
      model_comb(dg, cg, ma, md, we);
      slot = cyc % 16;
      for (int l = 1; l <= 2; l++) begin
        n_chk++;
        if (cpu_rvalid_o[l] !== rv_cpu[l][slot] || dma_rvalid_o[l] !== rv_dma[l][slot] ||
            cpu_rdata_o[l] !== (rv_cpu[l][slot] ? m_rdata : hold_cpu[l]) ||
            dma_rdata_o[l] !== (rv_dma[l][slot] ? m_rdata : hold_dma[l]) || dma_gnt_o[l] !== dg) begin
          n_fail++;
          $display("FAIL interleave k=%0d lat=%0d: cpu rv/d=%b/%h dma rv/d=%b/%h gnt=%b, want %b %b gnt=%b", k, l,
                   cpu_rvalid_o[l], cpu_rdata_o[l], dma_rvalid_o[l], dma_rdata_o[l], dma_gnt_o[l],
                   rv_cpu[l][slot], rv_dma[l][slot], dg);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    bit dg, cg, we;
    logic [31:0] ma, md;
    int slot;
    for (int k = 0; k < 600; k++) begin
      if (!(cpu_req && !last_cg)) begin
        cpu_req   = ($urandom_range(0, 99) < 60);
        cpu_we    = $urandom_range(0, 1);
        cpu_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255)) : $urandom;
        cpu_wdata = $urandom;
      end
      if (dma_req && !last_dg) begin
        if ($urandom_range(0, 9) == 0) dma_req = 0;
      end else begin
        dma_req   = ($urandom_range(0, 1) == 1);
        dma_we    = $urandom_range(0, 1);
        dma_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255)) : $urandom;
        dma_wdata = $urandom;
      end
      m_rdata = $urandom;
      @(negedge mem_clk);
      model_comb(dg, cg, ma, md, we);
      slot = cyc % 16;
      for (int l = 1; l <= 2; l++) begin
        n_chk++;
        if ({cpu_gnt_o[l], dma_gnt_o[l], cpu_stall_o[l], m_we_o[l], m_addr_o[l], m_datain_o[l]} !==
            {cg, dg, cpu_req && !cg, we, ma, md}) begin
          n_fail++;
          $display("FAIL rand_port k=%0d lat=%0d: cg=%b dg=%b st=%b we=%b a=%h d=%h, want %b %b %b %b %h %h", k, l,
                   cpu_gnt_o[l], dma_gnt_o[l], cpu_stall_o[l], m_we_o[l], m_addr_o[l], m_datain_o[l],
                   cg, dg, cpu_req && !cg, we, ma, md);
        end
        n_chk++;
        if (cpu_rvalid_o[l] !== rv_cpu[l][slot] || dma_rvalid_o[l] !== rv_dma[l][slot] || dma_err_o[l] !== err_exp) begin
          n_fail++;
          $display("FAIL rand_flags k=%0d lat=%0d: crv=%b drv=%b err=%b, want %b %b %b", k, l,
                   cpu_rvalid_o[l], dma_rvalid_o[l], dma_err_o[l], rv_cpu[l][slot], rv_dma[l][slot], err_exp);
        end
        n_chk++;
        if (cpu_rdata_o[l] !== (rv_cpu[l][slot] ? m_rdata : hold_cpu[l]) ||
            dma_rdata_o[l] !== (rv_dma[l][slot] ? m_rdata : hold_dma[l])) begin
          n_fail++;
          $display("FAIL rand_rdata k=%0d lat=%0d: cpu=%h dma=%h, want %h %h", k, l, cpu_rdata_o[l], dma_rdata_o[l],
                   rv_cpu[l][slot] ? m_rdata : hold_cpu[l], rv_dma[l][slot] ? m_rdata : hold_dma[l]);
        end
      end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_cpu_read();
    test_starvation();
    test_dma_io();
    test_cpu_io();
    test_interleaved();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (data RAM plus high-address I/O window) between the pipeline MEM stage (CPU) and a DMA/loader engine.
- Sits between both requesters and the data memory.
- CPU has fixed priority; a starvation counter guarantees DMA progress.
- The block muxes address, data and write-enable, returns read data to the owner, and blocks DMA accesses to the I/O window (addr[31:8] == 24'hffffff).

Parameters:
- MAX_WAIT, 4: cycles DMA may wait before a forced grant; legal range 1..255.
- RD_LAT, 1: memory read latency in mem_clk cycles; legal values 1 or 2.

Ports:
- mem_clk  in  1  clock; all state changes on its rising edge.
- clrn  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held while stalled.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_stall  out  1  combinational; cpu_req & ~cpu_gnt.
- cpu_gnt  out  1  combinational; CPU owns the port this cycle.
- cpu_rdata  out  32  CPU read return data.
- cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse.
- dma_req  in  1  DMA access request, held until dma_gnt.
- dma_we  in  1  DMA write/read.
- dma_addr  in  32  DMA byte address.
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  combinational; DMA owns the port this cycle.
- dma_rdata  out  32  DMA read return data.
- dma_rvalid  out  1  dma_rdata valid, one-cycle pulse.
- dma_err  out  1  registered pulse; the DMA access targeted the I/O window and was suppressed.
- m_addr  out  32  to memory.
- m_datain  out  32  to memory.
- m_we  out  1  to memory.
- m_rdata  in  32  from memory.

Behaviour:
- **Reset** (clrn low, asynchronous):
  - wait_cnt = 0; read-tag pipeline cleared.
  - cpu_rvalid = dma_rvalid = dma_err = 0; cpu_rdata = dma_rdata = 0.
  - Reads in flight when reset asserts are discarded and produce no rvalid.
- **Arbitration** (combinational, per cycle):
  - force = dma_req & (wait_cnt == MAX_WAIT).
  - dma_gnt = dma_req & (~cpu_req | force).
  - cpu_gnt = cpu_req & ~dma_gnt.
  - Neither requesting: m_addr = 0, m_datain = 0, m_we = 0.
- **Port mux:**
  - The owner's addr and wdata drive m_addr and m_datain.
  - m_we = owner_we, except on a DMA grant with an I/O-window address, where m_we = 0.
- **wait_cnt** (width 8):
  - Increments when dma_req & ~dma_gnt, saturating at MAX_WAIT.
  - Clears when dma_gnt or ~dma_req.
  - A forced grant therefore happens on the (MAX_WAIT+1)th cycle of contention.
- **Read return:**
  - Each granted read pushes tag {valid, owner} into an RD_LAT-deep shift register.
  - Suppressed DMA I/O reads push an invalid tag.
  - When a tag exits:
    - valid CPU tag: cpu_rdata <= m_rdata and cpu_rvalid = 1.
    - valid DMA tag: dma_rdata <= m_rdata and dma_rvalid = 1.
  - rdata registers hold their value between pulses.
  - Writes produce no rvalid.
- **Latency:** rvalid asserts exactly RD_LAT cycles after the grant cycle; back-to-back reads give back-to-back rvalid.
- **I/O protection:**
  - A DMA grant to addr[31:8] == 24'hffffff consumes the slot (dma_gnt = 1, wait_cnt clears).
  - No write occurs.
  - dma_err pulses 1 cycle after the grant.
  - CPU I/O-window accesses pass unchanged.
- **Simultaneous events:**
  - Both requesting with wait_cnt < MAX_WAIT: CPU wins.
  - A forced DMA grant stalls the CPU for exactly one cycle, then the CPU regains priority.
- **Requester rules:**
  - Requesters keep req, we, addr and wdata stable until granted.
  - Dropping req before grant is legal and clears wait_cnt (DMA).

Test Plan:
- **Reset:**
  - Stimulus: assert clrn=0 mid-read with RD_LAT=2.
  - Required: all outputs 0; no rvalid after release.
- **CPU read:**
  - Stimulus: CPU read 0x0000_0010 alone, m_rdata=0xDEADBEEF.
  - Required: cpu_gnt=1 and m_addr=0x10 in cycle 0; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in cycle 1 (RD_LAT=1).
- **Starvation:**
  - Stimulus: cpu_req held 1 and dma_req held 1, MAX_WAIT=4.
  - Required: CPU granted cycles 0–3; dma_gnt=1 and cpu_stall=1 in cycle 4; CPU granted in cycle 5.
- **DMA to I/O window:**
  - Stimulus: DMA write addr 0xFFFF_FF20, data 0x7F.
  - Required: dma_gnt=1, m_we=0, dma_err=1 next cycle, no dma_rvalid.
- **CPU to I/O window:**
  - Stimulus: CPU write 0xFFFF_FF80, data 0x3FF.
  - Required: m_we=1, m_addr=0xFFFF_FF80, m_datain=0x3FF.
- **Interleaved reads:**
  - Stimulus: alternating CPU/DMA reads with RD_LAT=2, DMA winning via idle CPU cycles.
  - Required: each rvalid goes to the correct owner exactly 2 cycles after its grant, with matching data.
